// File: rtl/xalu_acc.sv
// Accumulator ALU: single-cycle arithmetic/logic ops plus multi-cycle bit-serial rotates.
// The accumulator holds the last delivered result and can stand in for operand A.
module xalu_acc #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             src_acc,
    input  logic             cin,
    input  logic             com,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg_zero,
    output logic             equ,
    output logic             err
);

    localparam logic [3:0] OP_ADD = 4'd0, OP_AND = 4'd1, OP_OR  = 4'd2, OP_XOR = 4'd3,
                           OP_PSA = 4'd4, OP_PSB = 4'd5, OP_SHR = 4'd6, OP_SHL = 4'd7,
                           OP_SUB = 4'd8, OP_ROL = 4'd9, OP_ROR = 4'd10;

    typedef enum logic {IDLE, ROT} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] acc, a_eff, b_add, rot_w, rot_nxt;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   cnt;
    logic             rot_left, rot_com, rot_equ, rot_bit;
    logic             accept, rot_start;
    logic [WIDTH-1:0] op_res;
    logic             op_cout, op_ovf, op_err;
    logic             fin_valid;
    logic [WIDTH-1:0] fin_res;
    logic             fin_cout, fin_ovf, fin_equ, fin_err;

    assign in_ready  = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign a_eff     = src_acc ? acc : opa;
    // A zero rotate count finishes in one cycle, so only nonzero counts enter ROT.
    assign rot_start = accept && (op == OP_ROL || op == OP_ROR) && (opb[SHW-1:0] != '0);

    always_comb begin
        b_add   = (op == OP_SUB) ? ~opb : opb;
        sum     = {1'b0, a_eff} + {1'b0, b_add} + {{WIDTH{1'b0}}, cin};
        op_res  = a_eff;
        op_cout = 1'b0;
        op_ovf  = 1'b0;
        op_err  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                op_res  = sum[WIDTH-1:0];
                op_cout = sum[WIDTH];
                op_ovf  = (a_eff[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a_eff[WIDTH-1]);
            end
            OP_AND:         op_res = a_eff & opb;
            OP_OR:          op_res = a_eff | opb;
            OP_XOR:         op_res = a_eff ^ opb;
            OP_PSA:         op_res = a_eff;
            OP_PSB:         op_res = opb;
            OP_SHR: begin
                op_res  = {cin, a_eff[WIDTH-1:1]};
                op_cout = a_eff[0];
            end
            OP_SHL: begin
                op_res  = {a_eff[WIDTH-2:0], cin};
                op_cout = a_eff[WIDTH-1];
            end
            OP_ROL, OP_ROR: op_res = a_eff;
            default:        op_err = 1'b1;
        endcase
    end

    always_comb begin
        rot_nxt = rot_left ? {rot_w[WIDTH-2:0], rot_w[WIDTH-1]} : {rot_w[0], rot_w[WIDTH-1:1]};
        rot_bit = rot_left ? rot_w[WIDTH-1] : rot_w[0];
    end

    always_comb begin
        state_nxt = state;
        fin_valid = 1'b0;
        fin_res   = op_res ^ {WIDTH{com}};
        fin_cout  = op_cout;
        fin_ovf   = op_ovf;
        fin_equ   = (a_eff == opb);
        fin_err   = op_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (rot_start) state_nxt = ROT;
                    else           fin_valid = 1'b1;
                end
            end
            ROT: begin
                if (cnt == SHW'(1)) begin
                    state_nxt = IDLE;
                    fin_valid = 1'b1;
                    fin_res   = rot_nxt ^ {WIDTH{rot_com}};
                    fin_cout  = rot_bit;
                    fin_ovf   = 1'b0;
                    fin_equ   = rot_equ;
                    fin_err   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            rot_w     <= '0;
            rot_left  <= 1'b0;
            rot_com   <= 1'b0;
            rot_equ   <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg_zero  <= 1'b0;
            equ       <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (rot_start) begin
                rot_w    <= a_eff;
                cnt      <= opb[SHW-1:0];
                rot_left <= (op == OP_ROL);
                rot_com  <= com;
                rot_equ  <= (a_eff == opb);
            end else if (state == ROT) begin
                rot_w <= rot_nxt;
                cnt   <= cnt - SHW'(1);
            end
            if (fin_valid) begin
                result    <= fin_res;
                cout      <= fin_cout;
                ovf       <= fin_ovf;
                zero      <= (fin_res == '0);
                neg_zero  <= (fin_res == '1);
                equ       <= fin_equ;
                err       <= fin_err;
                acc       <= fin_res;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xalu_acc.sv
// Self-checking bench for xalu_acc (WIDTH=8): directed vectors plus randomized ops
// checked against an arithmetic reference model with its own accumulator copy.
module tb_xalu_acc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, src_acc, cin, com;
    logic         out_valid, out_ready, cout, ovf, zero, neg_zero, equ, err;
    logic [3:0]   op;
    logic [W-1:0] opa, opb, result;

    int checks = 0;
    int errors = 0;
    int exp_acc = 0;

    always #5 clk = ~clk;

    xalu_acc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .opa(opa), .opb(opb), .src_acc(src_acc), .cin(cin), .com(com),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cout(cout), .ovf(ovf), .zero(zero), .neg_zero(neg_zero), .equ(equ), .err(err)
    );

    // Expected {result, cout, ovf, zero, neg_zero, equ, err} and latency from plain arithmetic.
    task automatic model(input logic [3:0] o, input int a, input int b, input int ci, input int cm,
                         output logic [13:0] exp_v, output int lat);
        int r, c, v, er, sa, sb, s, n;
        r = a; c = 0; v = 0; er = 0; lat = 1;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (o)
            4'd0: begin s = a + b + ci; r = s % 256; c = s / 256;
                        v = (sa + sb + ci > 127 || sa + sb + ci < -128) ? 1 : 0; end
            4'd1: r = a & b;
            4'd2: r = a | b;
            4'd3: r = a ^ b;
            4'd4: r = a;
            4'd5: r = b;
            4'd6: begin r = a / 2 + ci * 128; c = a % 2; end
            4'd7: begin r = (a * 2 + ci) % 256; c = a / 128; end
            4'd8: begin s = a + (255 - b) + ci; r = s % 256; c = s / 256;
                        v = (sa - sb - 1 + ci > 127 || sa - sb - 1 + ci < -128) ? 1 : 0; end
            4'd9: begin n = b % 8; lat = n + 1;
                        if (n > 0) begin r = ((a << n) | (a >> (8 - n))) % 256; c = r % 2; end end
            4'd10: begin n = b % 8; lat = n + 1;
                        if (n > 0) begin r = ((a >> n) | (a << (8 - n))) % 256; c = r / 128; end end
            default: er = 1;
        endcase
        if (cm != 0) r = 255 - r;
        exp_v = {r[7:0], c[0], v[0], (r == 0), (r == 255), (a == b), er[0]};
    endtask

    // Issues one request with out_ready held high and returns the delivered outputs.
    task automatic run_op(input logic [3:0] o, input int a, input int b, input int s, input int ci,
                          input int cm, output logic [13:0] obs, output int lat, output bit to);
        int n;
        to = 1'b0; lat = 0; obs = '0;
        @(negedge clk);
        in_valid = 1'b1; op = o; opa = W'(a); opb = W'(b);
        src_acc = s[0]; cin = ci[0]; com = cm[0]; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (!in_ready) begin to = 1'b1; in_valid = 1'b0; return; end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!out_valid) to = 1'b1;
        obs = {result, cout, ovf, zero, neg_zero, equ, err};
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; opa = '0; opb = '0;
        src_acc = 1'b0; cin = 1'b0; com = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        checks++;
        if ({result, cout, ovf, zero, neg_zero, equ, err} !== 14'h0) begin
            errors++; $display("FAIL reset_outs: got %h, want 0", {result, cout, ovf, zero, neg_zero, equ, err});
        end
        exp_acc = 0;
    endtask

    task automatic test_add();
        logic [13:0] obs; int lat; bit to;
        run_op(4'd0, 8'hFF, 8'h01, 0, 0, 0, obs, lat, to);
        checks++;
        if (to || lat != 1 || obs !== {8'h00, 6'b101000}) begin
            errors++; $display("FAIL add_ff_01: got %h lat %0d, want %h lat 1", obs, lat, {8'h00, 6'b101000});
        end
        run_op(4'd0, 8'h7F, 8'h01, 0, 0, 0, obs, lat, to);
        checks++;
        if (to || lat != 1 || obs !== {8'h80, 6'b010000}) begin
            errors++; $display("FAIL add_7f_01: got %h lat %0d, want %h lat 1", obs, lat, {8'h80, 6'b010000});
        end
        exp_acc = 8'h80;
    endtask

    task automatic test_sub_acc();
        logic [13:0] obs; int lat; bit to;
        run_op(4'd8, 8'h50, 8'h70, 0, 1, 0, obs, lat, to);
        checks++;
        if (to || obs !== {8'hE0, 6'b000000}) begin
            errors++; $display("FAIL sub: got %h, want %h", obs, {8'hE0, 6'b000000});
        end
        run_op(4'd4, 8'h00, 8'h00, 1, 0, 1, obs, lat, to);
        checks++;
        if (to || obs !== {8'h1F, 6'b000000}) begin
            errors++; $display("FAIL acc_passa_com: got %h, want %h", obs, {8'h1F, 6'b000000});
        end
        exp_acc = 8'h1F;
    endtask

    task automatic test_rotate();
        logic [13:0] obs; int lat; bit to; bit bad;
        drain();
        in_valid = 1'b1; op = 4'd9; opa = 8'h81; opb = 8'h03; src_acc = 1'b0; cin = 1'b0; com = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rol_accept: in_ready=%b, want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rol_busy: in_ready/out_valid not 0 during rotate, want 0"); end
        obs = {result, cout, ovf, zero, neg_zero, equ, err};
        checks++;
        if (out_valid !== 1'b1 || obs !== {8'h0C, 6'b000000}) begin
            errors++; $display("FAIL rol_81_3: out_valid=%b got %h, want 1 %h", out_valid, obs, {8'h0C, 6'b000000});
        end
        run_op(4'd10, 8'h01, 8'h01, 0, 0, 0, obs, lat, to);
        checks++;
        if (to || lat != 2 || obs !== {8'h80, 6'b100010}) begin
            errors++; $display("FAIL ror_01_1: got %h lat %0d, want %h lat 2", obs, lat, {8'h80, 6'b100010});
        end
        exp_acc = 8'h80;
    endtask

    task automatic test_backpressure();
        logic [13:0] obs; bit bad;
        drain();
        in_valid = 1'b1; op = 4'd0; opa = 8'h10; opb = 8'h20; src_acc = 1'b0; cin = 1'b0; com = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        op = 4'd3; opa = 8'h0F; opb = 8'hFF;
        bad = 1'b0;
        repeat (3) begin
            #1;
            obs = {result, cout, ovf, zero, neg_zero, equ, err};
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs !== {8'h30, 6'b000000}) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin errors++; $display("FAIL stall_hold: result/flags or handshake moved while stalled, want 30 held"); end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: in_ready=%b, want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        obs = {result, cout, ovf, zero, neg_zero, equ, err};
        checks++;
        if (out_valid !== 1'b1 || obs !== {8'hF0, 6'b000000}) begin
            errors++; $display("FAIL stall_next: out_valid=%b got %h, want 1 %h", out_valid, obs, {8'hF0, 6'b000000});
        end
        exp_acc = 8'hF0;
    endtask

    task automatic test_reserved_and_rot_reset();
        logic [13:0] obs; int lat; bit to; bit seen;
        run_op(4'd12, 8'h5A, 8'h00, 0, 0, 0, obs, lat, to);
        checks++;
        if (to || lat != 1 || obs !== {8'h5A, 6'b000001}) begin
            errors++; $display("FAIL reserved: got %h, want %h", obs, {8'h5A, 6'b000001});
        end
        drain();
        in_valid = 1'b1; op = 4'd9; opa = 8'h81; opb = 8'h07; src_acc = 1'b0; cin = 1'b0; com = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rot_reset_ready: in_ready=%b, want 1", in_ready); end
        repeat (10) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        checks++;
        if (seen) begin errors++; $display("FAIL rot_reset_abort: out_valid rose, want never"); end
        run_op(4'd4, 8'hAA, 8'h00, 1, 0, 0, obs, lat, to);
        checks++;
        if (to || obs !== {8'h00, 6'b001010}) begin
            errors++; $display("FAIL rot_reset_acc: got %h, want %h", obs, {8'h00, 6'b001010});
        end
        exp_acc = 0;
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp_v, prev, obs; int lat, a, b, s, ci, cm, k; logic [3:0] o; bit bad;
        drain();
        bad = 1'b0;
        prev = '0;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                obs = {result, cout, ovf, zero, neg_zero, equ, err};
                checks++;
                if (out_valid !== 1'b1 || obs !== prev) begin
                    errors++; $display("FAIL b2b[%0d]: out_valid=%b got %h, want 1 %h", i - 1, out_valid, obs, prev);
                end
            end
            if (i == 16) begin in_valid = 1'b0; break; end
            k = $urandom_range(0, 13);
            o = (k <= 8) ? 4'(k) : 4'(k + 2);
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            s = $urandom_range(0, 1); ci = $urandom_range(0, 1); cm = $urandom_range(0, 1);
            model(o, (s != 0) ? exp_acc : a, b, ci, cm, prev, lat);
            exp_acc = prev[13:6];
            in_valid = 1'b1; op = o; opa = W'(a); opb = W'(b);
            src_acc = s[0]; cin = ci[0]; com = cm[0]; out_ready = 1'b1;
            #1;
            if (in_ready !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin errors++; $display("FAIL b2b_ready: in_ready dropped during back-to-back, want 1"); end
    endtask

    task automatic test_random();
        logic [13:0] exp_v, obs; int elat, lat, a, b, s, ci, cm; logic [3:0] o; bit to;
        for (int i = 0; i < 120; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            s = $urandom_range(0, 1); ci = $urandom_range(0, 1); cm = $urandom_range(0, 1);
            model(o, (s != 0) ? exp_acc : a, b, ci, cm, exp_v, elat);
            run_op(o, a, b, s, ci, cm, obs, lat, to);
            checks++;
            if (to || lat != elat || obs !== exp_v) begin
                errors++;
                $display("FAIL rand[%0d] op=%0d: got %h lat %0d, want %h lat %0d", i, o, obs, lat, exp_v, elat);
            end
            exp_acc = exp_v[13:6];
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_acc();
        test_rotate();
        test_backpressure();
        test_reserved_and_rot_reset();
        test_back_to_back();
        test_random();
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xalu_acc.md
XALU_ACC -- requirements
Module: xalu_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width (>=4).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), rotate-count width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port op  input  4  function code.
REQ-008 SHALL have port opa, opb  input  WIDTH each  operands A, B.
REQ-009 SHALL have port src_acc  input  1  1 = A taken from accumulator instead of opa.
REQ-010 SHALL have port cin  input  1  carry/shift-in bit.
REQ-011 SHALL have port com  input  1  1 = result one's-complemented.
REQ-012 SHALL have port out_valid  output  1  result and flags valid.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port result  output  WIDTH  registered result.
REQ-015 SHALL have ports cout, ovf, zero, neg_zero, equ, err  output  1 each  registered flags.

Function
REQ-016 SHALL accept a request only on a cycle with in_valid && in_ready; operands, op, cin, com sampled then.
REQ-017 SHALL drive in_ready = rst_n && state==IDLE && (!out_valid || out_ready).
REQ-018 SHALL decode op: 0 ADD A+B+cin; 1 AND; 2 OR; 3 XOR; 4 PASSA; 5 PASSB; 6 SHR by 1, cin into MSB; 7 SHL by 1, cin into LSB; 8 SUB A+~B+cin; 9 ROL A by B[SHW-1:0]; 10 ROR A by B[SHW-1:0]; 11-15 reserved.
REQ-019 SHALL complete ops 0-8 and 11-15 in one cycle: out_valid rises the cycle after acceptance.
REQ-020 SHALL implement ROL/ROR as FSM IDLE -> ROT -> IDLE, rotating one bit per cycle with a down-counter loaded with B[SHW-1:0]; out_valid rises count+1 cycles after acceptance (count 0 -> 1 cycle, result = A).
REQ-021 SHALL apply com as XOR of every result bit after the operation; flags zero/neg_zero evaluate the complemented value.
REQ-022 SHALL set cout: ADD/SUB = carry out of MSB; SHR = old A[0]; SHL = old A[WIDTH-1]; ROL/ROR = last bit wrapped (0 if count 0); all others 0.
REQ-023 SHALL set ovf = signed two's-complement overflow for ADD/SUB, else 0.
REQ-024 SHALL set zero = (result==0), neg_zero = (result all ones), equ = (A==B) on the effective operands.
REQ-025 SHALL, for reserved codes, produce result = A (then com), cout 0, ovf 0, err 1; err 0 for defined codes.
REQ-026 SHALL load the accumulator with the final result in the cycle out_valid rises; accumulator unchanged otherwise.
REQ-027 SHALL hold result and flags stable while out_valid && !out_ready; out_valid falls the cycle after out_ready when no new result completes.
REQ-028 SHALL allow back-to-back single-cycle ops: with out_ready held 1, one result per cycle.
REQ-029 SHALL ignore in_valid while in_ready is 0 (no queueing).

Reset
REQ-030 SHALL, on a clock edge with rst_n low, set state IDLE, counter 0, accumulator 0, result 0, all flags 0, out_valid 0.
REQ-031 SHALL abort an in-progress rotate on reset: no out_valid, accumulator 0.
REQ-032 SHALL show in_ready 1 in the first cycle after rst_n returns high.

Verification (WIDTH=8)
REQ-033 ADD opa=0xFF opb=0x01 cin=0 -> next cycle out_valid=1, result=0x00, cout=1, zero=1, ovf=0; ADD 0x7F+0x01 -> 0x80, ovf=1, cout=0.
REQ-034 SUB opa=0x50 opb=0x70 cin=1 -> result=0xE0, cout=0, ovf=0; then src_acc=1 PASSA com=1 -> result=0x1F.
REQ-035 ROL opa=0x81 opb=0x03 -> in_ready 0 for 3 cycles, out_valid 4 cycles after accept, result=0x0C, cout=0; ROR 0x01 by 1 -> 0x80, cout=1.
REQ-036 out_ready=0 for 3 cycles after a result -> result/flags stable, in_ready=0, in_valid ignored; out_ready=1 -> next request accepted same cycle.
REQ-037 op=12 opa=0x5A -> result=0x5A, err=1; rst_n low during ROL by 7 -> out_valid never rises, accumulator=0, in_ready=1 after release.
